// File: rtl/lfsr_prbs_gen.sv
// ----------------------------------------------------------------------------
// lfsr_prbs_gen
//
// Parameterised Fibonacci LFSR pseudo-random bit/word generator with seed
// loading, stepping enable, all-zero seed protection and on-line period
// measurement.
//
// The state register is a WIDTH-wide flip-flop bank. Each bit selects between
// the load value and the shifted/feedback value, and the result is held when
// the generator is idle.
//
// Parameters:
//   WIDTH         state width in bits (>= 2)
//   TAPS          feedback tap mask, bit i set => q[i] enters the XOR
//   SEED_DEFAULT  reset state and substitute for an all-zero seed (non-zero)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   load         load seed into the state this cycle (wins over en)
//   seed         seed value sampled when load=1
//   en           advance the LFSR one step this cycle
//   q            current LFSR state (registered)
//   bit_out      serial PRBS bit, the MSB of q
//   period_done  1-cycle pulse when q has returned to the start state
//   period       steps taken for the last completed period
//   seed_err     1-cycle pulse when a zero seed was replaced by SEED_DEFAULT
// ----------------------------------------------------------------------------
module lfsr_prbs_gen #(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] TAPS         = 4'b1001,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 4'b0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             period_done,
    output logic [WIDTH-1:0] period,
    output logic             seed_err
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // State the current measurement started from, and steps taken since.
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] step_cnt;

    logic             fb;
    logic [WIDTH-1:0] q_n;
    logic             seed_zero;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] step_inc;
    logic             wrap;

    // Feedback and next-state datapath. A zero seed would lock the register
    // in the all-zero state forever, so it is swapped for SEED_DEFAULT.
    // The step increment saturates so that a non-maximal tap set, whose
    // orbit never revisits the start state, simply pins the counter.
    always_comb begin
        fb        = ^(q & TAPS);
        q_n       = {q[WIDTH-2:0], fb};
        seed_zero = (seed == '0);
        load_val  = seed_zero ? SEED_DEFAULT : seed;
        step_inc  = (step_cnt == CNT_MAX) ? CNT_MAX : (step_cnt + CNT_ONE);
        wrap      = (q_n == start_q);
    end

    // State, measurement and pulse registers. Priority is reset, then load,
    // then step, then hold. Both pulses are cleared on every edge that does
    // not explicitly raise them, so they last exactly one cycle. A wrap
    // publishes the completed count and restarts the measurement from zero
    // so the pulse recurs every period.
    always_ff @(posedge clk) begin
        if (rst) begin
            q           <= SEED_DEFAULT;
            start_q     <= SEED_DEFAULT;
            step_cnt    <= '0;
            period      <= '0;
            period_done <= 1'b0;
            seed_err    <= 1'b0;
        end else if (load) begin
            q           <= load_val;
            start_q     <= load_val;
            step_cnt    <= '0;
            period_done <= 1'b0;
            seed_err    <= seed_zero;
        end else if (en) begin
            q        <= q_n;
            seed_err <= 1'b0;
            if (wrap) begin
                period_done <= 1'b1;
                period      <= step_inc;
                step_cnt    <= '0;
            end else begin
                period_done <= 1'b0;
                step_cnt    <= step_inc;
            end
        end else begin
            period_done <= 1'b0;
            seed_err    <= 1'b0;
        end
    end

    // The serial bit is taken straight from the state flop, so it is
    // registered without a separate stage.
    assign bit_out = q[WIDTH-1];

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// ----------------------------------------------------------------------------
// tb_lfsr_prbs_gen
//
// Directed self-checking bench for lfsr_prbs_gen. The main instance uses the
// default maximal-length configuration (x^4 + x^3 + 1 style taps 4'b1001).
// A second instance uses a non-maximal tap mask whose orbit never returns to
// its starting state, exercising the no-pulse case.
// ----------------------------------------------------------------------------
module tb_lfsr_prbs_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] seed;
    logic       en;

    logic [3:0] q;
    logic       bit_out;
    logic       period_done;
    logic [3:0] period;
    logic       seed_err;

    logic [3:0] nm_q;
    logic       nm_bit_out;
    logic       nm_period_done;
    logic [3:0] nm_period;
    logic       nm_seed_err;

    int checks   = 0;
    int failures = 0;

    // Hand-computed orbit of taps 4'b1001 starting at 4'b0001.
    logic [3:0] orbit [15] = '{
        4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
        4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0110,
        4'b1100, 4'b1001, 4'b0010, 4'b0100, 4'b1000
    };

    // 100 MHz style free-running clock.
    always #5 clk = ~clk;

    lfsr_prbs_gen #(
        .WIDTH        (4),
        .TAPS         (4'b1001),
        .SEED_DEFAULT (4'b0001)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .seed        (seed),
        .en          (en),
        .q           (q),
        .bit_out     (bit_out),
        .period_done (period_done),
        .period      (period),
        .seed_err    (seed_err)
    );

    lfsr_prbs_gen #(
        .WIDTH        (4),
        .TAPS         (4'b0010),
        .SEED_DEFAULT (4'b0001)
    ) dut_nm (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .seed        (seed),
        .en          (en),
        .q           (nm_q),
        .bit_out     (nm_bit_out),
        .period_done (nm_period_done),
        .period      (nm_period),
        .seed_err    (nm_seed_err)
    );

    // Drive one cycle worth of inputs, then wait for the edge that samples
    // them and settle 1 time unit past it before anything is observed.
    task automatic applyStimulus(input logic r, input logic l, input logic e,
                                 input logic [3:0] s);
        rst  = r;
        load = l;
        en   = e;
        seed = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checks++;
        if (q !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL reset_q: got %b expected 0001", q);
        end
        checks++;
        if (bit_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_bit_out: got %b expected 0", bit_out);
        end
        checks++;
        if (period !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_period: got %0d expected 0", period);
        end
        checks++;
        if (period_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_period_done: got %b expected 0", period_done);
        end
        checks++;
        if (seed_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_seed_err: got %b expected 0", seed_err);
        end
    endtask

    task automatic test_shift();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
            checks++;
            if (q !== orbit[i]) begin
                failures++;
                $display("[TB] FAIL shift_q step %0d: got %b expected %b", i, q, orbit[i]);
            end
            checks++;
            if (bit_out !== orbit[i][3]) begin
                failures++;
                $display("[TB] FAIL shift_bit_out step %0d: got %b expected %b",
                         i, bit_out, orbit[i][3]);
            end
        end
    endtask

    task automatic test_period();
        logic exp_done;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        for (int i = 1; i <= 30; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
            exp_done = (i == 15) || (i == 30);
            checks++;
            if (q !== orbit[i % 15]) begin
                failures++;
                $display("[TB] FAIL period_q step %0d: got %b expected %b", i, q, orbit[i % 15]);
            end
            checks++;
            if (period_done !== exp_done) begin
                failures++;
                $display("[TB] FAIL period_done step %0d: got %b expected %b",
                         i, period_done, exp_done);
            end
            if (exp_done) begin
                checks++;
                if (period !== 4'd15) begin
                    failures++;
                    $display("[TB] FAIL period_value step %0d: got %0d expected 15", i, period);
                end
            end
        end
    endtask

    task automatic test_zero_seed();
        // Move off the start state so the substitution is visible.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
        checks++;
        if (q !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL zero_seed_q: got %b expected 0001", q);
        end
        checks++;
        if (seed_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_seed_err: got %b expected 1", seed_err);
        end
        checks++;
        if (period !== 4'd15) begin
            failures++;
            $display("[TB] FAIL zero_seed_period_hold: got %0d expected 15", period);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        checks++;
        if (seed_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_seed_err_pulse: got %b expected 0", seed_err);
        end
        // Counter restarted at load: the wrap must come after exactly 15 steps.
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
            checks++;
            if (period_done !== (i == 15)) begin
                failures++;
                $display("[TB] FAIL zero_seed_done step %0d: got %b expected %b",
                         i, period_done, (i == 15));
            end
        end
    endtask

    task automatic test_load_priority();
        applyStimulus(1'b0, 1'b1, 1'b1, 4'b1010);
        checks++;
        if (q !== 4'b1010) begin
            failures++;
            $display("[TB] FAIL load_wins_q: got %b expected 1010", q);
        end
        checks++;
        if (seed_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_seed_err: got %b expected 0", seed_err);
        end
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
            checks++;
            if (q !== 4'b1010) begin
                failures++;
                $display("[TB] FAIL hold_q cycle %0d: got %b expected 1010", i, q);
            end
        end
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
            checks++;
            if (q !== orbit[(6 + i) % 15]) begin
                failures++;
                $display("[TB] FAIL load_orbit_q step %0d: got %b expected %b",
                         i, q, orbit[(6 + i) % 15]);
            end
            checks++;
            if (period_done !== (i == 15)) begin
                failures++;
                $display("[TB] FAIL load_done step %0d: got %b expected %b",
                         i, period_done, (i == 15));
            end
        end
        checks++;
        if (period !== 4'd15) begin
            failures++;
            $display("[TB] FAIL load_period: got %0d expected 15", period);
        end
    endtask

    task automatic test_reset_midrun();
        // Continue from start state 1010 for 7 steps, then reset.
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        checks++;
        if (q !== orbit[13]) begin
            failures++;
            $display("[TB] FAIL midrun_q: got %b expected %b", q, orbit[13]);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checks++;
        if (q !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL midrun_reset_q: got %b expected 0001", q);
        end
        checks++;
        if (period !== 4'd0) begin
            failures++;
            $display("[TB] FAIL midrun_reset_period: got %0d expected 0", period);
        end
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
            checks++;
            if (period_done !== (i == 15)) begin
                failures++;
                $display("[TB] FAIL midrun_done step %0d: got %b expected %b",
                         i, period_done, (i == 15));
            end
        end
        checks++;
        if (period !== 4'd15) begin
            failures++;
            $display("[TB] FAIL midrun_period: got %0d expected 15", period);
        end
    endtask

    task automatic test_nonmax();
        int pulses;
        // Taps 4'b0010 from 0001: 0010, 0101, 1010, 0101, 1010, ...
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
            if (nm_period_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("[TB] FAIL nonmax_pulses: got %0d expected 0", pulses);
        end
        checks++;
        if (nm_q !== 4'b0101) begin
            failures++;
            $display("[TB] FAIL nonmax_q: got %b expected 0101", nm_q);
        end
        checks++;
        if (nm_period !== 4'd0) begin
            failures++;
            $display("[TB] FAIL nonmax_period: got %0d expected 0", nm_period);
        end
        // Starting inside the 2-cycle, the orbit does return.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0101);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        checks++;
        if (nm_period_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nonmax_cycle_done step 1: got %b expected 0", nm_period_done);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        checks++;
        if (nm_period_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL nonmax_cycle_done step 2: got %b expected 1", nm_period_done);
        end
        checks++;
        if (nm_period !== 4'd2) begin
            failures++;
            $display("[TB] FAIL nonmax_cycle_period: got %0d expected 2", nm_period);
        end
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        en   = 1'b0;
        seed = 4'b0000;
        test_reset();
        test_shift();
        test_period();
        test_zero_seed();
        test_load_priority();
        test_reset_midrun();
        test_nonmax();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
